// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller and datapath.
// Enum values are FILL, RUN and STALL; EX_MEM field positions are shared with the datapath.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    // EX_MEM field positions, shared with the datapath
    localparam int unsigned EX_MEM_BRANCH_HI   = 3;
    localparam int unsigned EX_MEM_BRANCH_LO   = 2;
    localparam int unsigned EX_MEM_JUMP_BIT    = 7;
    localparam int unsigned EX_MEM_MUX1_OUT_HI = 169;
    localparam int unsigned EX_MEM_MUX1_OUT_LO = 165;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_flush;
        logic redirect;
        logic pipe_full;
    } ctrl_out_t;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load in EX writes.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  hazard
);

    logic rd_nonzero;
    logic rs_match;
    logic rt_match;

    // Register 0 is hardwired, so it never creates a dependency
    assign rd_nonzero = (ex_rd != '0);
    assign rs_match   = (ex_rd == id_rs);
    assign rt_match   = id_uses_rt && (ex_rd == id_rt);
    assign hazard     = ex_mem_read && rd_nonzero && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: fill suppression, load-use stalls, taken-redirect flushes.
// Optional performance counters are enabled with PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FILL_CYCLES       = 4,
    parameter int unsigned LOAD_STALL_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_branch_taken,
    input  logic                  mem_jump,
`ifdef PIPE_HAZARD_PERF_EN
    output logic [31:0]           stall_count,
    output logic [31:0]           flush_count,
`endif
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_flush,
    output logic                  redirect,
    output logic                  pipe_full
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_CYCLES - 1);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic             MULTI_STALL = (LOAD_STALL_CYCLES > 1);

    ctrl_state_e      state;
    ctrl_state_e      state_next;
    logic [CNT_W-1:0] fill_cnt;
    logic [CNT_W-1:0] fill_cnt_next;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] stall_cnt_next;
    logic             hazard;
    logic             take;
    ctrl_out_t        outs;

    load_use_detect u_load_use_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .hazard      (hazard)
    );

    assign take = mem_branch_taken | mem_jump;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= FILL;
            fill_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_next;
            fill_cnt  <= fill_cnt_next;
            stall_cnt <= stall_cnt_next;
        end
    end

    // Next-state and output decode; a taken redirect outranks any hazard
    always_comb begin
        state_next         = state;
        fill_cnt_next      = fill_cnt;
        stall_cnt_next     = stall_cnt;
        outs               = '0;
        outs.pc_write      = 1'b1;
        outs.if_id_write   = 1'b1;

        unique case (state)
            FILL: begin
                fill_cnt_next = fill_cnt + CNT_W'(1);
                if (fill_cnt == FILL_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                outs.pipe_full = 1'b1;
                if (take) begin
                    outs.redirect     = 1'b1;
                    outs.if_id_flush  = 1'b1;
                    outs.id_ex_bubble = 1'b1;
                    outs.ex_mem_flush = 1'b1;
                end else if (hazard) begin
                    outs.pc_write     = 1'b0;
                    outs.if_id_write  = 1'b0;
                    outs.id_ex_bubble = 1'b1;
                    if (MULTI_STALL) begin
                        state_next     = STALL;
                        stall_cnt_next = CNT_W'(1);
                    end
                end
            end
            STALL: begin
                outs.pipe_full = 1'b1;
                if (take) begin
                    outs.redirect     = 1'b1;
                    outs.if_id_flush  = 1'b1;
                    outs.id_ex_bubble = 1'b1;
                    outs.ex_mem_flush = 1'b1;
                    state_next        = RUN;
                    stall_cnt_next    = '0;
                end else begin
                    outs.pc_write     = 1'b0;
                    outs.if_id_write  = 1'b0;
                    outs.id_ex_bubble = 1'b1;
                    stall_cnt_next    = stall_cnt + CNT_W'(1);
                    if (stall_cnt == STALL_LAST) begin
                        state_next     = RUN;
                        stall_cnt_next = '0;
                    end
                end
            end
            default: begin
                state_next     = FILL;
                fill_cnt_next  = '0;
                stall_cnt_next = '0;
            end
        endcase
    end

    assign pc_write     = outs.pc_write;
    assign if_id_write  = outs.if_id_write;
    assign if_id_flush  = outs.if_id_flush;
    assign id_ex_bubble = outs.id_ex_bubble;
    assign ex_mem_flush = outs.ex_mem_flush;
    assign redirect     = outs.redirect;
    assign pipe_full    = outs.pipe_full;

`ifdef PIPE_HAZARD_PERF_EN
    // Saturating event counters; bubbles that come from a redirect are not stalls
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (outs.id_ex_bubble && !outs.redirect && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end
            if (outs.redirect && (flush_count != '1)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with single-cycle stalls, one with two-cycle stalls.
// Expected output vectors are queued as each step is driven and compared at the following falling edge.
module tb_pipe_hazard_ctrl;

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, redirect, pipe_full}
    localparam logic [6:0] O_FILL  = 7'b1100000;
    localparam logic [6:0] O_RUN   = 7'b1100001;
    localparam logic [6:0] O_STALL = 7'b0001001;
    localparam logic [6:0] O_TAKE  = 7'b1111111;

    typedef struct {
        string      tag;
        logic       rst_v;
        logic [6:0] o1;
        logic [6:0] o2;
    } exp_t;

    logic       clock;
    logic       reset;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       mem_branch_taken;
    logic       mem_jump;

    logic pc_write1, if_id_write1, if_id_flush1, id_ex_bubble1, ex_mem_flush1, redirect1, pipe_full1;
    logic pc_write2, if_id_write2, if_id_flush2, id_ex_bubble2, ex_mem_flush2, redirect2, pipe_full2;
    logic [6:0] obs1;
    logic [6:0] obs2;

    exp_t sb[$];
    int   n_check = 0;
    int   n_pass  = 0;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_count1, flush_count1, stall_count2, flush_count2;
    logic [31:0] exp_stall1 = 0, exp_flush1 = 0, exp_stall2 = 0, exp_flush2 = 0;
`endif

    assign obs1 = {pc_write1, if_id_write1, if_id_flush1, id_ex_bubble1, ex_mem_flush1, redirect1, pipe_full1};
    assign obs2 = {pc_write2, if_id_write2, if_id_flush2, id_ex_bubble2, ex_mem_flush2, redirect2, pipe_full2};

    pipe_hazard_ctrl #(.FILL_CYCLES(4), .LOAD_STALL_CYCLES(1)) dut1 (
        .clock            (clock),
        .reset            (reset),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rt       (id_uses_rt),
        .ex_mem_read      (ex_mem_read),
        .ex_rd            (ex_rd),
        .mem_branch_taken (mem_branch_taken),
        .mem_jump         (mem_jump),
`ifdef PIPE_HAZARD_PERF_EN
        .stall_count      (stall_count1),
        .flush_count      (flush_count1),
`endif
        .pc_write         (pc_write1),
        .if_id_write      (if_id_write1),
        .if_id_flush      (if_id_flush1),
        .id_ex_bubble     (id_ex_bubble1),
        .ex_mem_flush     (ex_mem_flush1),
        .redirect         (redirect1),
        .pipe_full        (pipe_full1)
    );

    pipe_hazard_ctrl #(.FILL_CYCLES(4), .LOAD_STALL_CYCLES(2)) dut2 (
        .clock            (clock),
        .reset            (reset),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rt       (id_uses_rt),
        .ex_mem_read      (ex_mem_read),
        .ex_rd            (ex_rd),
        .mem_branch_taken (mem_branch_taken),
        .mem_jump         (mem_jump),
`ifdef PIPE_HAZARD_PERF_EN
        .stall_count      (stall_count2),
        .flush_count      (flush_count2),
`endif
        .pc_write         (pc_write2),
        .if_id_write      (if_id_write2),
        .if_id_flush      (if_id_flush2),
        .id_ex_bubble     (id_ex_bubble2),
        .ex_mem_flush     (ex_mem_flush2),
        .redirect         (redirect2),
        .pipe_full        (pipe_full2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_vec(input string tag, input string which, input logic [31:0] got,
                             input logic [31:0] want);
        n_check++;
        assert (got === want) n_pass++;
        else $error("FAIL %s %s observed %h expected %h", tag, which, got, want);
    endtask

    // One clock step: drive after the rising edge, compare at the falling edge
    task automatic step(input string tag, input logic rst_v, input logic [4:0] rs,
                        input logic [4:0] rt, input logic uses, input logic rd_en,
                        input logic [4:0] rd, input logic br, input logic jmp,
                        input logic [6:0] e1, input logic [6:0] e2);
        exp_t e;
        @(posedge clock);
        #1;
        reset            = rst_v;
        id_rs            = rs;
        id_rt            = rt;
        id_uses_rt       = uses;
        ex_mem_read      = rd_en;
        ex_rd            = rd;
        mem_branch_taken = br;
        mem_jump         = jmp;
        sb.push_back('{tag: tag, rst_v: rst_v, o1: e1, o2: e2});
        @(negedge clock);
        e = sb.pop_front();
        check_vec(e.tag, "outs1", 32'(obs1), 32'(e.o1));
        check_vec(e.tag, "outs2", 32'(obs2), 32'(e.o2));
`ifdef PIPE_HAZARD_PERF_EN
        if (!e.rst_v) begin
            exp_stall1 = 0; exp_flush1 = 0; exp_stall2 = 0; exp_flush2 = 0;
        end
        check_vec(e.tag, "stall_count1", stall_count1, exp_stall1);
        check_vec(e.tag, "flush_count1", flush_count1, exp_flush1);
        check_vec(e.tag, "stall_count2", stall_count2, exp_stall2);
        check_vec(e.tag, "flush_count2", flush_count2, exp_flush2);
        if (e.rst_v) begin
            if (e.o1 == O_STALL) exp_stall1++;
            if (e.o1 == O_TAKE)  exp_flush1++;
            if (e.o2 == O_STALL) exp_stall2++;
            if (e.o2 == O_TAKE)  exp_flush2++;
        end
`endif
    endtask

    initial begin
        reset = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        ex_rd = '0; mem_branch_taken = 1'b0; mem_jump = 1'b0;

        //   tag            rst  rs     rt     use  rd_en rd     br   jmp   dut1     dut2
        step("reset",       0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_FILL,  O_FILL);
        step("fill_c0",     1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, O_FILL,  O_FILL);
        step("fill_c1",     1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, O_FILL,  O_FILL);
        step("fill_c2",     1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, O_FILL,  O_FILL);
        step("fill_c3_haz", 1, 5'd5, 5'd0, 0, 1, 5'd5, 0, 1, O_FILL,  O_FILL);
        step("run_c4_jmp",  1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, O_TAKE,  O_TAKE);
        step("ld_rs",       1, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, O_STALL, O_STALL);
        step("ld_rs_p1",    1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_RUN,   O_STALL);
        step("ld_rs_p2",    1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_RUN,   O_RUN);
        step("rd_zero",     1, 5'd0, 5'd0, 0, 1, 5'd0, 0, 0, O_RUN,   O_RUN);
        step("rt_unused",   1, 5'd3, 5'd5, 0, 1, 5'd5, 0, 0, O_RUN,   O_RUN);
        step("not_load",    1, 5'd7, 5'd0, 0, 0, 5'd7, 0, 0, O_RUN,   O_RUN);
        step("ld_rt9",      1, 5'd2, 5'd9, 1, 1, 5'd9, 0, 0, O_STALL, O_STALL);
        step("ld_rt9_p1",   1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_RUN,   O_STALL);
        step("ld_rt9_p2",   1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_RUN,   O_RUN);
        step("haz_and_br",  1, 5'd5, 5'd0, 0, 1, 5'd5, 1, 0, O_TAKE,  O_TAKE);
        step("no_stall_in", 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_RUN,   O_RUN);
        step("stall_a",     1, 5'd6, 5'd0, 0, 1, 5'd6, 0, 0, O_STALL, O_STALL);
        step("stall_b_br",  1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, O_TAKE,  O_TAKE);
        step("abort_after", 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_RUN,   O_RUN);
        step("run_jmp",     1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, O_TAKE,  O_TAKE);
        step("pre_reset",   1, 5'd8, 5'd0, 0, 1, 5'd8, 0, 0, O_STALL, O_STALL);
        step("reset_stall", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_FILL,  O_FILL);
        step("refill_c0",   1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, O_FILL,  O_FILL);
        step("refill_c1",   1, 5'd4, 5'd0, 0, 1, 5'd4, 1, 0, O_FILL,  O_FILL);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
